// File: rtl/router_pkt_ctrl.sv
// Packet write controller for three router output FIFOs: decodes headers, steers bytes,
// applies back-pressure, checks parity and runs a per-FIFO read-timeout watchdog.
module router_pkt_ctrl #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned TCNT_W  = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic [2:0] soft_reset,
    output logic       parity_err,
    output logic       addr_err,
    output logic       pkt_done
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrop
    } state_e;

    state_e            state_q;
    logic [6:0]        cnt_q;
    logic [1:0]        addr_q;
    logic [7:0]        parity_acc_q;
    logic [TCNT_W-1:0] wd_q [3];

    logic [1:0] hdr_addr;
    logic [3:0] full_ext;
    logic [3:0] sr_ext;
    logic       accept;
    logic       abort;
    logic       last_byte;

    // Pad to four entries so address 3 indexes a defined, inactive slot.
    assign hdr_addr  = data_in[1:0];
    assign full_ext  = {1'b0, fifo_full};
    assign sr_ext    = {1'b0, soft_reset};
    assign accept    = pkt_valid & ~busy;
    assign abort     = (state_q == StLoad) & sr_ext[addr_q];
    assign last_byte = (cnt_q == 7'd1);

    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            StIdle:  busy = pkt_valid & (hdr_addr != 2'd3) & full_ext[hdr_addr];
            StLoad:  busy = full_ext[addr_q];
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        write_enb = 3'b000;
        lfd_state = 1'b0;
        if (accept) begin
            if (state_q == StIdle && hdr_addr != 2'd3) begin
                write_enb = 3'(4'b0001 << hdr_addr);
                lfd_state = 1'b1;
            end else if (state_q == StLoad && !abort) begin
                write_enb = 3'(4'b0001 << addr_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            addr_q       <= '0;
            parity_acc_q <= '0;
            parity_err   <= 1'b0;
            addr_err     <= 1'b0;
            pkt_done     <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            pkt_done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_q <= {1'b0, data_in[7:2]} + 7'd1;
                        if (hdr_addr == 2'd3) begin
                            addr_err <= 1'b1;
                            state_q  <= StDrop;
                        end else begin
                            addr_q       <= hdr_addr;
                            parity_acc_q <= data_in;
                            state_q      <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (abort) begin
                        // Target FIFO was flushed: discard the rest of this packet.
                        if (accept) begin
                            cnt_q   <= cnt_q - 7'd1;
                            state_q <= last_byte ? StIdle : StDrop;
                        end else begin
                            state_q <= StDrop;
                        end
                    end else if (accept) begin
                        cnt_q <= cnt_q - 7'd1;
                        if (last_byte) begin
                            pkt_done   <= 1'b1;
                            parity_err <= (data_in != parity_acc_q);
                            state_q    <= StIdle;
                        end else begin
                            parity_acc_q <= parity_acc_q ^ data_in;
                        end
                    end
                end
                StDrop: begin
                    if (accept) begin
                        cnt_q <= cnt_q - 7'd1;
                        if (last_byte) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The pulse cycle itself never counts, so consecutive timeouts are TIMEOUT+1 apart.
    always_ff @(posedge clock) begin
        if (reset) begin
            soft_reset <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                wd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                soft_reset[i] <= 1'b0;
                if (soft_reset[i] || read_enb[i] || fifo_empty[i]) begin
                    wd_q[i] <= '0;
                end else if (wd_q[i] == TCNT_W'(TIMEOUT - 1)) begin
                    wd_q[i]       <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    wd_q[i] <= wd_q[i] + TCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Bench for router_pkt_ctrl: random packets against a packet-level model of FIFO contents.
module tb_router_pkt_ctrl;

    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic       busy;
    logic [2:0] soft_reset;
    logic       parity_err;
    logic       addr_err;
    logic       pkt_done;

    router_pkt_ctrl #(
        .TIMEOUT(TIMEOUT),
        .TCNT_W (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .read_enb  (read_enb),
        .write_enb (write_enb),
        .lfd_state (lfd_state),
        .busy      (busy),
        .soft_reset(soft_reset),
        .parity_err(parity_err),
        .addr_err  (addr_err),
        .pkt_done  (pkt_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    logic [7:0] got_q[3][$];
    logic [7:0] exp_q[3][$];
    int n_ticks, n_writes, busy_cycles, viol, lfd_cnt, pd_cnt, pe_cnt, ae_cnt;
    int sr_cnt[3];
    int exp_pd, exp_pe, exp_ae;
    int full_left = 0;
    logic [2:0] full_mask = 3'b000;
    logic last_busy;
    logic [2:0] last_sr;

    task automatic clear_logs();
        for (int f = 0; f < 3; f++) begin
            got_q[f].delete();
            exp_q[f].delete();
            sr_cnt[f] = 0;
        end
        n_ticks = 0; n_writes = 0; busy_cycles = 0; viol = 0; lfd_cnt = 0;
        pd_cnt = 0; pe_cnt = 0; ae_cnt = 0; exp_pd = 0; exp_pe = 0; exp_ae = 0;
    endtask

    // One clock cycle: inputs already set at the falling edge, sample 1ns later, log.
    task automatic tick();
        if (full_left > 0) begin
            fifo_full = full_mask;
            full_left--;
        end else begin
            fifo_full = 3'b000;
        end
        #1;
        n_ticks++;
        if (busy && pkt_valid) busy_cycles++;
        if (write_enb != 3'b000) begin
            n_writes++;
            for (int f = 0; f < 3; f++) if (write_enb[f]) got_q[f].push_back(data_in);
        end
        if ($countones(write_enb) > 1) viol++;
        if (write_enb != 3'b000 && (!pkt_valid || busy)) viol++;
        if (lfd_state) begin
            lfd_cnt++;
            if (write_enb == 3'b000) viol++;
        end
        if (pkt_done) pd_cnt++;
        if (parity_err) begin
            pe_cnt++;
            if (!pkt_done) viol++;
        end
        if (addr_err) ae_cnt++;
        for (int f = 0; f < 3; f++) if (soft_reset[f]) sr_cnt[f]++;
        last_busy = busy;
        last_sr   = soft_reset;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00; read_enb = 3'b000;
        fifo_empty = 3'b111; full_left = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic flush();
        pkt_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic put_byte(input logic [7:0] b, input bit stall_en);
        int guard = 0;
        if (stall_en && $urandom_range(0, 2) == 0) begin
            pkt_valid = 1'b0;
            data_in   = 8'($urandom);
            tick();
        end
        pkt_valid = 1'b1;
        data_in   = b;
        tick();
        while (last_busy) begin
            guard++;
            if (guard > 64) begin
                checks++;
                $display("FAIL put_byte_wait: busy still 1 after 64 cycles, want 0");
                break;
            end
            tick();
        end
        pkt_valid = 1'b0;
    endtask

    // Model: a valid-address packet lands whole in its FIFO; parity is XOR of header+payload.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] perr_mask,
                            input bit stall_en, input int full_after);
        logic [7:0] bytes[$];
        logic [7:0] par;
        logic [7:0] b;
        int len;
        len = int'(hdr[7:2]);
        par = hdr;
        bytes.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            par = par ^ b;
        end
        bytes.push_back(par ^ perr_mask);
        if (hdr[1:0] != 2'd3) begin
            foreach (bytes[i]) exp_q[hdr[1:0]].push_back(bytes[i]);
            exp_pd++;
            if (perr_mask != 8'h00) exp_pe++;
        end else begin
            exp_ae++;
        end
        for (int i = 0; i < bytes.size(); i++) begin
            put_byte(bytes[i], stall_en);
            if (i == full_after) begin
                full_left = 5;
                full_mask = 3'(4'b0001 << hdr[1:0]);
            end
        end
    endtask

    function automatic int q_mismatch(input int f);
        int bad;
        int n;
        bad = (got_q[f].size() > exp_q[f].size()) ? got_q[f].size() - exp_q[f].size()
                                                   : exp_q[f].size() - got_q[f].size();
        n = (got_q[f].size() < exp_q[f].size()) ? got_q[f].size() : exp_q[f].size();
        for (int i = 0; i < n; i++) if (got_q[f][i] !== exp_q[f][i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        do_reset();
        clear_logs();
        #1;
        checks++;
        if ({write_enb, lfd_state, busy} !== 5'b0) $display("FAIL reset_comb: got %b want 00000", {write_enb, lfd_state, busy});
        else passed++;
        checks++;
        if ({soft_reset, parity_err, addr_err, pkt_done} !== 6'b0) $display("FAIL reset_regs: got %b want 000000", {soft_reset, parity_err, addr_err, pkt_done});
        else passed++;
        pkt_valid = 1'b1; data_in = 8'h05; fifo_full = 3'b010;
        #1;
        checks++;
        if ({busy, write_enb} !== 4'b1000) $display("FAIL idle_busy_full: got %b want 1000", {busy, write_enb});
        else passed++;
        data_in = 8'h07; fifo_full = 3'b111;
        #1;
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy_addr3: got %b want 0", busy);
        else passed++;
        pkt_valid = 1'b0; fifo_full = 3'b000;
        @(negedge clock);
    endtask

    task automatic test_good_packet();
        int t;
        clear_logs();
        send_pkt(8'h39, 8'h00, 1'b0, -1);
        t = n_ticks;
        flush();
        checks++;
        if (t !== 16 || n_writes !== 16) $display("FAIL good_consecutive: got %0d cycles %0d writes want 16 16", t, n_writes);
        else passed++;
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (q_mismatch(f) !== 0) $display("FAIL good_fifo%0d: got %0d bytes (%0d bad) want %0d bytes", f, got_q[f].size(), q_mismatch(f), exp_q[f].size());
            else passed++;
        end
        checks++;
        if (lfd_cnt !== 1 || busy_cycles !== 0) $display("FAIL good_lfd_busy: got lfd %0d busy %0d want 1 0", lfd_cnt, busy_cycles);
        else passed++;
        checks++;
        if (pd_cnt !== 1 || pe_cnt !== 0) $display("FAIL good_done: got done %0d perr %0d want 1 0", pd_cnt, pe_cnt);
        else passed++;
    endtask

    task automatic test_parity_error();
        clear_logs();
        send_pkt(8'h39, 8'h01, 1'b0, -1);
        flush();
        checks++;
        if (q_mismatch(1) !== 0 || n_writes !== 16) $display("FAIL perr_written: got %0d writes want 16", n_writes);
        else passed++;
        checks++;
        if (pe_cnt !== 1 || pd_cnt !== 1 || viol !== 0) $display("FAIL perr_pulse: got perr %0d done %0d viol %0d want 1 1 0", pe_cnt, pd_cnt, viol);
        else passed++;
    endtask

    task automatic test_addr_error();
        clear_logs();
        send_pkt(8'h0B, 8'h00, 1'b0, -1);
        send_pkt(8'h04, 8'h00, 1'b0, -1);
        flush();
        checks++;
        if (ae_cnt !== 1) $display("FAIL addr_err_pulse: got %0d want 1", ae_cnt);
        else passed++;
        checks++;
        if (n_writes !== 3 || q_mismatch(0) !== 0) $display("FAIL addr_err_writes: got %0d writes want 3 into fifo0", n_writes);
        else passed++;
        checks++;
        if (pd_cnt !== 1 || lfd_cnt !== 1) $display("FAIL addr_err_next: got done %0d lfd %0d want 1 1", pd_cnt, lfd_cnt);
        else passed++;
    endtask

    task automatic test_backpressure();
        clear_logs();
        send_pkt(8'h39, 8'h00, 1'b0, 4);
        flush();
        checks++;
        if (busy_cycles !== 5) $display("FAIL bp_busy_cycles: got %0d want 5", busy_cycles);
        else passed++;
        checks++;
        if (n_writes !== 16 || q_mismatch(1) !== 0 || viol !== 0) $display("FAIL bp_writes: got %0d writes viol %0d want 16 0", n_writes, viol);
        else passed++;
        checks++;
        if (pe_cnt !== 0 || pd_cnt !== 1) $display("FAIL bp_done: got perr %0d done %0d want 0 1", pe_cnt, pd_cnt);
        else passed++;
    endtask

    task automatic test_watchdog();
        int first;
        int second;
        int read_at;
        int exp_first;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            clear_logs();
            read_at = (run == 0) ? -1 : 20;
            first = -1;
            second = -1;
            fifo_empty = 3'b011;
            for (int c = 0; c < 90; c++) begin
                read_enb = (c == read_at) ? 3'b100 : 3'b000;
                tick();
                if (last_sr[2]) begin
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                end
            end
            read_enb = 3'b000;
            fifo_empty = 3'b111;
            exp_first = read_at + 1 + TIMEOUT;
            checks++;
            if (first !== exp_first) $display("FAIL wd_first_run%0d: got %0d want %0d", run, first, exp_first);
            else passed++;
            checks++;
            if (second !== exp_first + 1 + TIMEOUT) $display("FAIL wd_second_run%0d: got %0d want %0d", run, second, exp_first + 1 + TIMEOUT);
            else passed++;
            checks++;
            if (sr_cnt[0] + sr_cnt[1] !== 0) $display("FAIL wd_other_fifos: got %0d pulses want 0", sr_cnt[0] + sr_cnt[1]);
            else passed++;
        end
    endtask

    task automatic test_abort_and_midreset();
        logic [7:0] bytes[$];
        logic [7:0] par;
        logic [7:0] b;
        int guard;
        do_reset();
        clear_logs();
        fifo_empty = 3'b101;
        par = 8'h29;
        bytes.push_back(8'h29);
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            par = par ^ b;
        end
        bytes.push_back(par);
        for (int i = 0; i < 4; i++) begin
            put_byte(bytes[i], 1'b0);
            exp_q[1].push_back(bytes[i]);
        end
        guard = 0;
        while (sr_cnt[1] == 0 && guard < 60) begin
            tick();
            guard++;
        end
        checks++;
        if (sr_cnt[1] !== 1 || 3 + guard !== TIMEOUT) $display("FAIL abort_timeout: got fire cycle %0d want %0d", 3 + guard, TIMEOUT);
        else passed++;
        fifo_empty = 3'b111;
        for (int i = 4; i < 12; i++) put_byte(bytes[i], 1'b1);
        flush();
        checks++;
        if (q_mismatch(1) !== 0) $display("FAIL abort_dropped: got %0d bytes want %0d", got_q[1].size(), exp_q[1].size());
        else passed++;
        checks++;
        if (pd_cnt !== 0 || pe_cnt !== 0) $display("FAIL abort_no_done: got done %0d perr %0d want 0 0", pd_cnt, pe_cnt);
        else passed++;
        send_pkt({6'($urandom_range(0, 9)), 2'b01}, 8'h00, 1'b1, -1);
        flush();
        checks++;
        if (q_mismatch(1) !== 0 || pd_cnt !== 1) $display("FAIL abort_next_pkt: got %0d bytes done %0d want %0d 1", got_q[1].size(), pd_cnt, exp_q[1].size());
        else passed++;

        clear_logs();
        put_byte(8'h39, 1'b0);
        for (int i = 0; i < 5; i++) put_byte(8'($urandom), 1'b0);
        reset = 1'b1;
        pkt_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({write_enb, lfd_state, busy, soft_reset, parity_err, addr_err, pkt_done} !== 11'b0) $display("FAIL midreset_outputs: got %b want 0", {write_enb, lfd_state, busy, soft_reset, parity_err, addr_err, pkt_done});
        else passed++;
        @(negedge clock);
        clear_logs();
        send_pkt({6'($urandom_range(0, 8)), 2'b10}, 8'h00, 1'b0, -1);
        flush();
        checks++;
        if (q_mismatch(2) !== 0 || lfd_cnt !== 1 || pd_cnt !== 1) $display("FAIL midreset_idle: got %0d bytes lfd %0d done %0d want %0d 1 1", got_q[2].size(), lfd_cnt, pd_cnt, exp_q[2].size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        int exp_ticks = 0;
        logic [7:0] hdr;
        clear_logs();
        for (int p = 0; p < 3; p++) begin
            hdr = {6'($urandom_range(1, 6)), 2'($urandom_range(0, 2))};
            exp_ticks += int'(hdr[7:2]) + 2;
            send_pkt(hdr, 8'h00, 1'b0, -1);
        end
        checks++;
        if (n_ticks !== exp_ticks) $display("FAIL b2b_no_gap: got %0d cycles want %0d", n_ticks, exp_ticks);
        else passed++;
        flush();
        checks++;
        if (q_mismatch(0) + q_mismatch(1) + q_mismatch(2) !== 0) $display("FAIL b2b_data: got %0d bad bytes want 0", q_mismatch(0) + q_mismatch(1) + q_mismatch(2));
        else passed++;
        checks++;
        if (pd_cnt !== 3 || lfd_cnt !== 3) $display("FAIL b2b_done: got done %0d lfd %0d want 3 3", pd_cnt, lfd_cnt);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] hdr;
        logic [7:0] perr;
        int fa;
        do_reset();
        clear_logs();
        for (int p = 0; p < 12; p++) begin
            hdr  = {6'($urandom_range(0, 12)), 2'($urandom_range(0, 3))};
            perr = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            fa   = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, int'(hdr[7:2]) + 1);
            send_pkt(hdr, perr, 1'b1, fa);
        end
        flush();
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (q_mismatch(f) !== 0) $display("FAIL rand_fifo%0d: got %0d bytes (%0d bad) want %0d bytes", f, got_q[f].size(), q_mismatch(f), exp_q[f].size());
            else passed++;
        end
        checks++;
        if (pd_cnt !== exp_pd || pe_cnt !== exp_pe || ae_cnt !== exp_ae) $display("FAIL rand_pulses: got %0d/%0d/%0d want %0d/%0d/%0d", pd_cnt, pe_cnt, ae_cnt, exp_pd, exp_pe, exp_ae);
        else passed++;
        checks++;
        if (lfd_cnt !== exp_pd || viol !== 0) $display("FAIL rand_lfd_onehot: got lfd %0d viol %0d want %0d 0", lfd_cnt, viol, exp_pd);
        else passed++;
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_good_packet();
        test_parity_error();
        test_addr_error();
        test_backpressure();
        test_back_to_back();
        test_watchdog();
        test_abort_and_midreset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/router_pkt_ctrl.md
Name: router_pkt_ctrl

Overview:
- Packet-level write controller for the router's three output FIFOs.
- Accepts the byte stream from the input port and decodes each header byte: bits [1:0] are the destination address, bits [7:2] are the payload length.
- Steers header, payload and parity bytes into the selected FIFO through per-FIFO write_enb and lfd_state, back-pressures the source while the target FIFO is full, and checks parity.
- Runs one independent read-timeout watchdog per FIFO that issues that FIFO's soft_reset.

Parameters:
TIMEOUT, 30, consecutive unread cycles with a non-empty FIFO before that FIFO's soft_reset fires (range 2..31)
TCNT_W, 5, width of each watchdog counter; must satisfy 2**TCNT_W > TIMEOUT

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
pkt_valid  in  1  data_in holds a valid byte this cycle
data_in  in  8  packet byte stream; the FIFOs take data_in directly
fifo_full  in  3  full flag per FIFO
fifo_empty  in  3  empty flag per FIFO
read_enb  in  3  read strobe per FIFO from the output side
write_enb  out  3  one-hot write strobe; combinational, same cycle as byte acceptance
lfd_state  out  1  high with the header write only
busy  out  1  combinational back-pressure; source holds data_in while busy=1
soft_reset  out  3  registered one-cycle pulse per FIFO
parity_err  out  1  registered one-cycle pulse: parity mismatch
addr_err  out  1  registered one-cycle pulse: header address 2'b11
pkt_done  out  1  registered one-cycle pulse: parity byte written

Behaviour:
- Reset values:
  - All outputs 0, state IDLE.
  - cnt, addr_q, parity_acc and all watchdog counters 0.
  - Reset mid-packet abandons the packet. Bytes already written remain in the FIFO; the FIFO's own reset or soft_reset handles them.
- Acceptance: a byte is accepted when pkt_valid=1 and busy=0.
- busy is combinational:
  - IDLE: pkt_valid & (data_in[1:0]!=3) & fifo_full[data_in[1:0]].
  - LOAD: fifo_full[addr_q].
  - DROP: 0.
- pkt_valid=0 mid-packet is a stall. State, cnt and parity_acc hold.
- IDLE, header accepted:
  - If addr=3: addr_err pulses the next cycle, cnt=len+1, go to DROP. No write occurs.
  - Otherwise: write_enb[addr]=1 and lfd_state=1 that cycle; addr_q=addr, cnt=len+1, parity_acc=data_in; go to LOAD.
  - A header with len=0 gives cnt=1, so the next byte is the parity byte.
- LOAD, byte accepted:
  - write_enb[addr_q]=1 and cnt decrements.
  - If cnt>1: parity_acc ^= data_in.
  - If cnt==1 (parity byte): compare data_in with parity_acc. pkt_done pulses the next cycle; parity_err also pulses if they differ. Go to IDLE.
  - The parity byte is always written, even on mismatch.
- DROP: each accepted byte decrements cnt and nothing is written. Go to IDLE when an accepted byte has cnt==1.
- Abort:
  - Applies when soft_reset[addr_q]=1 in LOAD.
  - No write that cycle; any byte accepted that cycle is discarded and decrements cnt. Go to DROP.
  - If that byte was the last one (cnt==1), go to IDLE instead.
  - No pkt_done or parity_err for the aborted packet.
- Watchdog i (independent per FIFO):
  - Counter increments on each cycle with fifo_empty[i]=0 & read_enb[i]=0.
  - It clears on read_enb[i]=1 or fifo_empty[i]=1.
  - When the counter reaches TIMEOUT, soft_reset[i] pulses high the next cycle and the counter clears.
  - The counter does not count during the soft_reset[i] cycle.
- Back-to-back packets: a header may be accepted in the cycle immediately after the parity byte.
- write_enb is never more than one-hot. lfd_state never coincides with a payload or parity write.

Test Plan:
1. Reset, then header 8'h39 (len 14, addr 1), 14 random payload bytes, correct parity, with pkt_valid held high -> write_enb=3'b010 for 16 consecutive cycles; lfd_state high on the first cycle only; pkt_done pulses once; parity_err=0; busy=0 throughout.
2. Same packet but parity byte = correct^8'h01 -> all 16 bytes written; parity_err and pkt_done pulse in the same cycle.
3. Header 8'h0B (len 2, addr 3), then 3 bytes -> addr_err pulses; write_enb stays 0 for all 4 bytes; the next header 8'h04 (len 1, addr 0) is accepted and written to FIFO 0.
4. Packet 8'h39 with fifo_full[1] forced high for 5 cycles after payload byte 4 -> busy=1 and write_enb=0 for those 5 cycles; byte 5 held on data_in is written when full drops; total writes 16; parity_err=0.
5. fifo_empty[2]=0 and read_enb[2]=0 from cycle 0 -> soft_reset[2] pulses at cycle 30. Rerun with a read_enb[2] pulse at cycle 20 -> soft_reset[2] pulses at cycle 51.
6. Header 8'h29 (len 10, addr 1), 3 payload bytes written, then a FIFO 1 timeout fires -> write_enb[1] stays 0 for the remaining bytes, which are dropped; no pkt_done; the next packet is written normally. Separately, reset asserted mid-packet -> all outputs 0 and state IDLE on the next cycle.
